// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store access unit: memory op encoding, FSM states
// and size/alignment helpers.
package mips_mem_pkg;

    typedef enum logic [3:0] {
        LB  = 4'h0,
        LBU = 4'h1,
        LH  = 4'h2,
        LHU = 4'h3,
        LW  = 4'h4,
        SB  = 4'h8,
        SH  = 4'h9,
        SW  = 4'hA
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_byte(input logic [3:0] op);
        return (op == LB) || (op == LBU) || (op == SB);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == LH) || (op == LHU) || (op == SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == LW) || (op == SW);
    endfunction

    function automatic logic is_onehot4(input logic [3:0] lane);
        return (lane != 4'b0000) && ((lane & (lane - 4'd1)) == 4'b0000);
    endfunction

    // Only meaningful for one-hot lanes; anything else is rejected upstream.
    function automatic logic [1:0] lane_to_offset(input logic [3:0] lane);
        logic [1:0] off;
        off = 2'd0;
        if (lane[1]) off = 2'd1;
        if (lane[2]) off = 2'd2;
        if (lane[3]) off = 2'd3;
        return off;
    endfunction

endpackage

// File: rtl/mips_mem_access_if.sv
// Avalon-style word bus between the access unit (master) and memory (slave).
interface mips_mem_access_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_load_extract.sv
// Picks the addressed byte/half/word out of a bus word and sign- or
// zero-extends it for register writeback.
module mips_load_extract
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_readdata,
    input  logic [1:0]  i_offset,
    input  logic [3:0]  i_op,
    output logic [31:0] o_result
);
    logic [31:0] w_shifted;
    logic        w_sign_byte;
    logic        w_sign_half;

    assign w_shifted   = i_readdata >> {i_offset, 3'b000};
    assign w_sign_byte = (i_op == LB) & w_shifted[7];
    assign w_sign_half = (i_op == LH) & w_shifted[15];

    always_comb begin
        o_result = w_shifted;
        if (is_byte(i_op)) begin
            o_result = {{24{w_sign_byte}}, w_shifted[7:0]};
        end else if (is_half(i_op)) begin
            o_result = {{16{w_sign_half}}, w_shifted[15:0]};
        end
    end
endmodule

// File: rtl/mips_mem_access.sv
// Load/store access unit: one word-aligned bus transfer per request with
// lane-shifted store data and extended load results.
module mips_mem_access
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        byte_lane,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [DATA_W-1:0] load_data,
    mips_mem_access_if.master bus
);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    state_e             r_state;
    state_e             w_state_next;
    logic [3:0]         r_op;
    logic [1:0]         r_offset;
    logic [ADDR_W-1:0]  r_address;
    logic [3:0]         r_byteenable;
    logic [DATA_W-1:0]  r_writedata;
    logic               r_misaligned;
    logic [DATA_W-1:0]  r_load_data;

    logic [1:0]         w_offset;
    logic               w_aligned;
    logic               w_misaligned;
    logic [3:0]         w_be;
    logic [DATA_W-1:0]  w_lane_mask;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_extracted;
    logic               w_accept;
    logic               w_complete;

    assign w_offset = lane_to_offset(byte_lane);

    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        if (is_byte(op)) begin
            w_aligned = 1'b1;
            w_be      = byte_lane;
        end else if (is_half(op)) begin
            w_aligned = ~w_offset[0];
            w_be      = w_offset[1] ? 4'b1100 : 4'b0011;
        end else if (is_word(op)) begin
            w_aligned = (w_offset == 2'd0);
            w_be      = 4'b1111;
        end
    end

    // An undefined op leaves w_aligned low, so it is rejected here as well.
    assign w_misaligned = ~is_onehot4(byte_lane) | ~w_aligned;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign w_lane_mask[8*gi +: 8] = {8{w_be[gi]}};
        end
    endgenerate

    assign w_wdata    = op[3] ? ((wdata_in << {w_offset, 3'b000}) & w_lane_mask) : '0;
    assign w_accept   = (r_state == IDLE) & start;
    assign w_complete = (r_state == REQ) & ~bus.waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobes are decoded from the state register so that an asynchronous
    // reset removes them immediately.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                busy      = 1'b1;
                bus.read  = ~r_op[3];
                bus.write = r_op[3];
                if (!bus.waitrequest) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op         <= 4'h0;
            r_offset     <= 2'd0;
            r_address    <= '0;
            r_byteenable <= 4'b0000;
            r_writedata  <= '0;
            r_misaligned <= 1'b0;
            r_load_data  <= '0;
        end else begin
            if (w_accept) begin
                r_misaligned <= w_misaligned;
                if (!w_misaligned) begin
                    r_op         <= op;
                    r_offset     <= w_offset;
                    r_address    <= addr & WORD_MASK;
                    r_byteenable <= w_be;
                    r_writedata  <= w_wdata;
                end
            end
            if (w_complete && !r_op[3]) begin
                r_load_data <= w_extracted;
            end
        end
    end

    mips_load_extract u_extract (
        .i_readdata (bus.readdata),
        .i_offset   (r_offset),
        .i_op       (r_op),
        .o_result   (w_extracted)
    );

    assign bus.address    = r_address;
    assign bus.byteenable = r_byteenable;
    assign bus.writedata  = r_writedata;
    assign misaligned     = r_misaligned;
    assign load_data      = r_load_data;

endmodule

// File: tb/tb_mips_mem_access.sv
// Bench for mips_mem_access: directed vector table, asynchronous reset
// sequence and randomized transfers checked against a behavioural model.
module tb_mips_mem_access;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [3:0]  lane;
        logic [31:0] wd;
        logic [31:0] rd;
        int          nwait;
        bit          noise;
        bit          exp_mis;
        int          exp_lat;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [3:0]  byte_lane = 4'h0;
    logic [31:0] wdata_in = 32'h0;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Observations of the most recent transaction.
    int          o_lat;
    int          o_strobes;
    bit          o_done_seen;
    bit          o_stable;
    bit          o_seen_rd;
    bit          o_seen_wr;
    logic        o_mis;
    logic [31:0] o_ld;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wd;
    logic        o_done_after;

    logic [31:0] model_ld = 32'h0;
    vec_t        vecs[13];

    mips_mem_access_if bus ();

    always #5 clk = ~clk;

    mips_mem_access #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .byte_lane  (byte_lane),
        .wdata_in   (wdata_in),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .load_data  (load_data),
        .bus        (bus.master)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Behavioural reference: size from the op, offset from the one-hot lane,
    // everything else by plain arithmetic.
    function automatic vec_t model(input logic [3:0] m_op, input logic [31:0] m_addr,
                                   input logic [3:0] m_lane, input logic [31:0] m_wd,
                                   input logic [31:0] m_rd, input int m_nwait,
                                   input logic [31:0] prev_ld);
        vec_t    v;
        int      size;
        int      off;
        longint  span;
        longint  field;
        case (m_op)
            4'h0, 4'h1, 4'h8: size = 1;
            4'h2, 4'h3, 4'h9: size = 2;
            4'h4, 4'hA:       size = 4;
            default:          size = 0;
        endcase
        off = 0;
        for (int k = 0; k < 4; k++) if (m_lane == (4'b0001 << k)) off = k;
        v.op = m_op; v.addr = m_addr; v.lane = m_lane; v.wd = m_wd; v.rd = m_rd;
        v.nwait = m_nwait; v.noise = 1'b0;
        v.exp_mis  = (size == 0) || ($countones(m_lane) != 1) || ((off % ((size == 0) ? 1 : size)) != 0);
        v.exp_lat  = v.exp_mis ? 1 : m_nwait + 2;
        v.exp_addr = m_addr - (m_addr % 4);
        span       = 64'sd1 <<< (8 * size);
        v.exp_be   = 4'((((64'sd1 <<< size) - 1) <<< off));
        v.exp_wd   = 32'(((longint'(m_wd)) % span) <<< (8 * off));
        v.exp_ld   = prev_ld;
        if (!v.exp_mis && !m_op[3]) begin
            field = (longint'(m_rd) >>> (8 * off)) % span;
            if ((m_op == 4'h0 || m_op == 4'h2) && field >= span / 2) field = field - span;
            v.exp_ld = 32'(field);
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        op = v.op; addr = v.addr; byte_lane = v.lane; wdata_in = v.wd;
        bus.readdata = v.rd; bus.waitrequest = (v.nwait > 0); start = 1'b1;
        o_lat = 0; o_strobes = 0; o_done_seen = 0; o_stable = 1; o_seen_rd = 0; o_seen_wr = 0;
        o_mis = 1'bx; o_ld = 'x; o_addr = 'x; o_be = 'x; o_wd = 'x;
        for (int cyc = 1; cyc <= 60 && !o_done_seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.read || bus.write) begin
                o_strobes++;
                if (o_strobes == 1) begin
                    o_addr = bus.address; o_be = bus.byteenable; o_wd = bus.writedata;
                end else if (bus.address !== o_addr || bus.byteenable !== o_be || bus.writedata !== o_wd) begin
                    o_stable = 0;
                end
                o_seen_rd |= bus.read;
                o_seen_wr |= bus.write;
                bus.waitrequest = (o_strobes <= v.nwait);
            end
            if (done) begin
                o_done_seen = 1; o_lat = cyc; o_mis = misaligned; o_ld = load_data;
            end else if (v.noise && busy) begin
                start = 1'b1; op = 4'h4; addr = $urandom; byte_lane = 4'b0001; wdata_in = $urandom;
            end
        end
        start = 1'b0;
        bus.waitrequest = 1'b0;
        @(negedge clk);
        o_done_after = done;
    endtask

    task automatic check_txn(input vec_t v, input string tag);
        txn_no++;
        chk({tag, " done_seen"}, 32'(o_done_seen), 32'd1);
        chk({tag, " misaligned"}, 32'(o_mis), 32'(v.exp_mis));
        chk({tag, " latency"}, 32'(o_lat), 32'(v.exp_lat));
        chk({tag, " done_one_cycle"}, 32'(o_done_after), 32'd0);
        chk({tag, " load_data"}, o_ld, v.exp_ld);
        if (v.exp_mis) begin
            chk({tag, " no_strobe"}, 32'(o_strobes), 32'd0);
        end else begin
            chk({tag, " strobe_cycles"}, 32'(o_strobes), 32'(v.nwait + 1));
            chk({tag, " read_seen"}, 32'(o_seen_rd), 32'(!v.op[3]));
            chk({tag, " write_seen"}, 32'(o_seen_wr), 32'(v.op[3]));
            chk({tag, " address"}, o_addr, v.exp_addr);
            chk({tag, " byteenable"}, 32'(o_be), 32'(v.exp_be));
            chk({tag, " stable"}, 32'(o_stable), 32'd1);
            if (v.op[3]) chk({tag, " writedata"}, o_wd, v.exp_wd);
        end
        $display("txn %0d %s op=%h addr=%h lane=%b waits=%0d lat=%0d mis=%0b ld=%h",
                 txn_no, tag, v.op, v.addr, v.lane, v.nwait, o_lat, o_mis, o_ld);
    endtask

    initial begin
        //           op     addr          lane     wd            rd            w  n  mis lat eaddr         be       ewd           eld
        vecs[0]  = '{4'h4, 32'h0000_1000, 4'b0001, 32'h0,        32'hDEADBEEF, 0, 0, 0, 2, 32'h0000_1000, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{4'h0, 32'h0000_1003, 4'b1000, 32'h0,        32'h80112233, 0, 0, 0, 2, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{4'h1, 32'h0000_1003, 4'b1000, 32'h0,        32'h80112233, 0, 0, 0, 2, 32'h0000_1000, 4'b1000, 32'h0,        32'h00000080};
        vecs[3]  = '{4'h9, 32'h0000_2002, 4'b0100, 32'h0000ABCD, 32'h0,        0, 0, 0, 2, 32'h0000_2000, 4'b1100, 32'hABCD0000, 32'h00000080};
        vecs[4]  = '{4'h8, 32'h0000_3001, 4'b0010, 32'h12345678, 32'h0,        3, 1, 0, 5, 32'h0000_3000, 4'b0010, 32'h00007800, 32'h00000080};
        vecs[5]  = '{4'h4, 32'h0000_4002, 4'b0100, 32'h0,        32'h55555555, 0, 0, 1, 1, 32'h0,        4'b0000, 32'h0,        32'h00000080};
        vecs[6]  = '{4'h2, 32'h0000_4000, 4'b1111, 32'h0,        32'h55555555, 0, 0, 1, 1, 32'h0,        4'b0000, 32'h0,        32'h00000080};
        vecs[7]  = '{4'h2, 32'h0000_5002, 4'b0100, 32'h0,        32'h80011234, 0, 0, 0, 2, 32'h0000_5000, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[8]  = '{4'h3, 32'h0000_5002, 4'b0100, 32'h0,        32'h80011234, 0, 0, 0, 2, 32'h0000_5000, 4'b1100, 32'h0,        32'h00008001};
        vecs[9]  = '{4'hA, 32'h0000_6000, 4'b0001, 32'hCAFEBABE, 32'h0,        1, 0, 0, 3, 32'h0000_6000, 4'b1111, 32'hCAFEBABE, 32'h00008001};
        vecs[10] = '{4'h5, 32'h0000_6000, 4'b0001, 32'h0,        32'h0,        0, 0, 1, 1, 32'h0,        4'b0000, 32'h0,        32'h00008001};
        vecs[11] = '{4'h0, 32'h0000_7002, 4'b0100, 32'h0,        32'h11AA2233, 0, 0, 0, 2, 32'h0000_7000, 4'b0100, 32'h0,        32'hFFFFFFAA};
        vecs[12] = '{4'h9, 32'h0000_7000, 4'b0001, 32'h1234ABCD, 32'h0,        2, 0, 0, 4, 32'h0000_7000, 4'b0011, 32'h0000ABCD, 32'hFFFFFFAA};

        bus.waitrequest = 1'b0;
        bus.readdata    = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst read", 32'(bus.read), 32'd0);
        chk("rst write", 32'(bus.write), 32'd0);
        chk("rst address", bus.address, 32'd0);
        chk("rst writedata", bus.writedata, 32'd0);
        chk("rst byteenable", 32'(bus.byteenable), 32'd0);
        chk("rst load_data", load_data, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i]);
            check_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while a read is stalled
        @(negedge clk);
        op = 4'h4; addr = 32'h0000_8000; byte_lane = 4'b0001; bus.waitrequest = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("arst read_before", 32'(bus.read), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst read", 32'(bus.read), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst byteenable", 32'(bus.byteenable), 32'd0);
        chk("arst load_data", load_data, 32'd0);
        model_ld = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.waitrequest = 1'b0;
        begin
            vec_t v;
            v = model(4'h4, 32'h0000_8000, 4'b0001, 32'h0, 32'h0BADF00D, 0, model_ld);
            run_txn(v);
            check_txn(v, "post_reset_lw");
            model_ld = v.exp_ld;
        end

        // Randomized transfers against the behavioural model
        for (int n = 0; n < 150; n++) begin
            vec_t        v;
            logic [3:0]  r_op_sel;
            logic [31:0] r_addr;
            logic [3:0]  r_lane;
            int          pick;
            pick = $urandom_range(0, 9);
            case (pick)
                0: r_op_sel = 4'h0; 1: r_op_sel = 4'h1; 2: r_op_sel = 4'h2; 3: r_op_sel = 4'h3;
                4: r_op_sel = 4'h4; 5: r_op_sel = 4'h8; 6: r_op_sel = 4'h9; 7: r_op_sel = 4'hA;
                8: r_op_sel = 4'h5; default: r_op_sel = 4'hF;
            endcase
            r_addr = $urandom;
            r_lane = 4'b0001 << r_addr[1:0];
            if ($urandom_range(0, 7) == 0) r_lane = 4'($urandom);
            v = model(r_op_sel, r_addr, r_lane, $urandom, $urandom, $urandom_range(0, 3), model_ld);
            run_txn(v);
            check_txn(v, "rand");
            model_ld = v.exp_ld;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
